// File: rtl/lockin_demod.sv
// Lock-in I/Q demodulator: multiplies the ADC error signal by the sine and
// cosine references, integrates each product over a programmable window and
// emits scaled, saturated I/Q words once per window.
module lockin_demod #(
  parameter int WORD_W = 16,
  parameter int ACC_W  = 48,
  parameter int CFG_W  = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable,
  input  logic signed [WORD_W-1:0] adc_in,
  input  logic signed [WORD_W-1:0] sine_ref,
  input  logic signed [WORD_W-1:0] cosine_ref,
  input  logic        [CFG_W-1:0]  n_samples,
  input  logic        [5:0]        out_shift,
  output logic signed [WORD_W-1:0] i_out,
  output logic signed [WORD_W-1:0] q_out,
  output logic                     iq_valid,
  output logic                     window_active
);

  localparam int PROD_W = 2 * WORD_W;

  localparam logic signed [ACC_W-1:0] SAT_MAX =
    {{(ACC_W-WORD_W+1){1'b0}}, {(WORD_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN =
    {{(ACC_W-WORD_W+1){1'b1}}, {(WORD_W-1){1'b0}}};

  typedef enum logic {IDLE, ACCUM} state_t;

  state_t state, next_state;

  logic signed [WORD_W-1:0] adc_r, sin_r, cos_r;
  logic                     v1, v2;
  logic signed [PROD_W-1:0] p_i, p_q;
  logic signed [ACC_W-1:0]  acc_i, acc_q;
  logic        [CFG_W-1:0]  cnt, len;

  logic        [CFG_W-1:0]  len_new, len_eff, cnt_base;
  logic signed [ACC_W-1:0]  acc_i_base, acc_q_base, sum_i, sum_q;
  logic signed [ACC_W-1:0]  shifted_i, shifted_q;
  logic                     last;

  // Clamp a shifted accumulator into the output word range.
  function automatic logic signed [WORD_W-1:0] sat(input logic signed [ACC_W-1:0] v);
    if (v > SAT_MAX)      sat = SAT_MAX[WORD_W-1:0];
    else if (v < SAT_MIN) sat = SAT_MIN[WORD_W-1:0];
    else                  sat = v[WORD_W-1:0];
  endfunction

  // Stage 1: capture the sample, both references and the run flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      adc_r <= '0;
      sin_r <= '0;
      cos_r <= '0;
      v1    <= 1'b0;
    end else begin
      adc_r <= adc_in;
      sin_r <= sine_ref;
      cos_r <= cosine_ref;
      v1    <= enable;
    end
  end

  // Stage 2: full-width signed products against both references.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      p_i <= '0;
      p_q <= '0;
      v2  <= 1'b0;
    end else begin
      p_i <= PROD_W'(adc_r) * PROD_W'(sin_r);
      p_q <= PROD_W'(adc_r) * PROD_W'(cos_r);
      v2  <= v1;
    end
  end

  // Window control: in IDLE the first valid product starts a fresh window,
  // so the accumulator/counter/length are taken as zero/zero/new length.
  always_comb begin
    len_new    = (n_samples == '0) ? CFG_W'(1) : n_samples;
    len_eff    = len;
    cnt_base   = cnt;
    acc_i_base = acc_i;
    acc_q_base = acc_q;
    next_state = state;
    if (state == IDLE) begin
      len_eff    = len_new;
      cnt_base   = '0;
      acc_i_base = '0;
      acc_q_base = '0;
    end
    sum_i     = acc_i_base + {{(ACC_W-PROD_W){p_i[PROD_W-1]}}, p_i};
    sum_q     = acc_q_base + {{(ACC_W-PROD_W){p_q[PROD_W-1]}}, p_q};
    shifted_i = sum_i >>> out_shift;
    shifted_q = sum_q >>> out_shift;
    last      = v2 && (cnt_base == len_eff - CFG_W'(1));
    next_state = v2 ? ACCUM : IDLE;
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= next_state;
  end

  // Stage 3: accumulate, close windows and register the scaled results.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_i    <= '0;
      acc_q    <= '0;
      cnt      <= '0;
      len      <= '0;
      i_out    <= '0;
      q_out    <= '0;
      iq_valid <= 1'b0;
    end else begin
      iq_valid <= 1'b0;
      if (!v2) begin
        acc_i <= '0;
        acc_q <= '0;
        cnt   <= '0;
      end else if (last) begin
        acc_i    <= '0;
        acc_q    <= '0;
        cnt      <= '0;
        len      <= len_new;
        i_out    <= sat(shifted_i);
        q_out    <= sat(shifted_q);
        iq_valid <= 1'b1;
      end else begin
        acc_i <= sum_i;
        acc_q <= sum_q;
        cnt   <= cnt_base + CFG_W'(1);
        if (state == IDLE) len <= len_new;
      end
    end
  end

  assign window_active = (state == ACCUM);

endmodule

// File: tb/tb_lockin_demod.sv
// Self-checking bench for lockin_demod with a sample-stream reference model.
module tb_lockin_demod;

  logic               clk = 1'b0;
  logic               rst;
  logic               enable;
  logic signed [15:0] adc_in, sine_ref, cosine_ref;
  logic        [31:0] n_samples;
  logic        [5:0]  out_shift;
  logic signed [15:0] i_out, q_out;
  logic               iq_valid, window_active;

  int total = 0;
  int bad   = 0;

  // Reference model: two-deep sample delay plus window arithmetic on longints.
  longint m1_pi, m1_pq, m2_pi, m2_pq;
  bit     m1_v, m2_v;
  bit     act;
  longint si, sq;
  int     cnt, len;
  bit     exp_valid;
  longint exp_i, exp_q;

  lockin_demod dut (
    .clk           (clk),
    .rst           (rst),
    .enable        (enable),
    .adc_in        (adc_in),
    .sine_ref      (sine_ref),
    .cosine_ref    (cosine_ref),
    .n_samples     (n_samples),
    .out_shift     (out_shift),
    .i_out         (i_out),
    .q_out         (q_out),
    .iq_valid      (iq_valid),
    .window_active (window_active)
  );

  // 250 MHz clock.
  always #2 clk = ~clk;

  function automatic longint sat(input longint v);
    if (v > 32767)  return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  task automatic check(input string tag, input logic signed [47:0] obs,
                       input logic signed [47:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    m1_pi = 0; m1_pq = 0; m1_v = 0;
    m2_pi = 0; m2_pq = 0; m2_v = 0;
    act = 0; si = 0; sq = 0; cnt = 0; len = 0;
    exp_valid = 0; exp_i = 0; exp_q = 0;
  endtask

  // One clock: capture what the DUT sees, advance the model, then compare.
  task automatic step();
    longint pi, pq;
    bit     v;
    int     nlen, sh;
    v    = enable;
    pi   = longint'(adc_in) * longint'(sine_ref);
    pq   = longint'(adc_in) * longint'(cosine_ref);
    nlen = (n_samples == 0) ? 1 : int'(n_samples);
    sh   = int'(out_shift);
    @(posedge clk);
    exp_valid = 0;
    if (m2_v) begin
      if (!act) begin
        act = 1; len = nlen; si = 0; sq = 0; cnt = 0;
      end
      si += m2_pi;
      sq += m2_pq;
      cnt++;
      if (cnt == len) begin
        exp_i = sat(si >>> sh);
        exp_q = sat(sq >>> sh);
        exp_valid = 1;
        si = 0; sq = 0; cnt = 0; len = nlen;
      end
    end else begin
      act = 0; si = 0; sq = 0; cnt = 0;
    end
    m2_pi = m1_pi; m2_pq = m1_pq; m2_v = m1_v;
    m1_pi = pi;    m1_pq = pq;    m1_v = v;
    #1;
    check("model_valid",  iq_valid,      exp_valid);
    check("model_i",      i_out,         exp_i);
    check("model_q",      q_out,         exp_q);
    check("model_active", window_active, act);
  endtask

  task automatic steps(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  initial begin
    rst = 1'b0; enable = 1'b0;
    adc_in = 0; sine_ref = 0; cosine_ref = 0;
    n_samples = 4; out_shift = 2;
    model_reset();
    #1;
    check("reset_i", i_out, 0);
    check("reset_q", q_out, 0);
    check("reset_valid", iq_valid, 0);
    check("reset_active", window_active, 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;

    $display("[TB] basic window, shift 2");
    enable = 1; adc_in = 100; sine_ref = 200; cosine_ref = -50;
    for (int k = 0; k < 5; k++) begin
      step();
      check("t1_no_early_pulse", iq_valid, 0);
    end
    step();
    check("t1_first_valid", iq_valid, 1);
    check("t1_i", i_out, 20000);
    check("t1_q", q_out, -5000);
    for (int k = 0; k < 3; k++) begin
      step();
      check("t1_one_cycle_pulse", iq_valid, 0);
    end
    step();
    check("t1_repeat_valid", iq_valid, 1);
    check("t1_repeat_i", i_out, 20000);

    $display("[TB] saturation");
    out_shift = 0;
    steps(4);
    check("t2_valid", iq_valid, 1);
    check("t2_i_sat", i_out, 32767);
    check("t2_q", q_out, -20000);
    cosine_ref = -200;
    steps(8);
    check("t2_valid_neg", iq_valid, 1);
    check("t2_q_sat", q_out, -32768);

    $display("[TB] single-sample windows");
    n_samples = 0; adc_in = 10; sine_ref = 3;
    steps(12);
    for (int k = 0; k < 4; k++) begin
      step();
      check("t3_valid_every", iq_valid, 1);
      check("t3_i", i_out, 30);
      check("t3_q", q_out, -2000);
    end

    $display("[TB] partial window discard");
    enable = 0; n_samples = 4; out_shift = 2;
    adc_in = 100; sine_ref = 200; cosine_ref = -50;
    steps(4);
    enable = 1;
    steps(2);
    enable = 0;
    for (int k = 0; k < 5; k++) begin
      step();
      check("t4_no_partial_pulse", iq_valid, 0);
    end
    enable = 1;
    for (int k = 0; k < 5; k++) begin
      step();
      check("t4_no_early_pulse", iq_valid, 0);
    end
    step();
    check("t4_valid", iq_valid, 1);
    check("t4_i", i_out, 20000);
    check("t4_q", q_out, -5000);

    $display("[TB] mid-window length change");
    out_shift = 3;
    steps(2);
    n_samples = 8;
    steps(2);
    check("t5_old_len_valid", iq_valid, 1);
    check("t5_old_len_i", i_out, 10000);
    check("t5_old_len_q", q_out, -2500);
    for (int k = 0; k < 7; k++) begin
      step();
      check("t5_no_pulse", iq_valid, 0);
    end
    step();
    check("t5_new_len_valid", iq_valid, 1);
    check("t5_new_len_i", i_out, 20000);
    check("t5_new_len_q", q_out, -5000);

    $display("[TB] randomized traffic");
    for (int k = 0; k < 400; k++) begin
      adc_in     = 16'($urandom);
      sine_ref   = 16'($urandom);
      cosine_ref = 16'($urandom);
      enable     = ($urandom_range(0, 15) != 0);
      if ($urandom_range(0, 9) == 0) n_samples = $urandom_range(0, 9);
      out_shift  = 6'($urandom_range(0, 24));
      step();
    end

    $display("[TB] asynchronous reset mid-window");
    enable = 1; n_samples = 4; out_shift = 2;
    adc_in = 100; sine_ref = 200; cosine_ref = -50;
    steps(8);
    check("t6_pre_reset_active", window_active, 1);
    rst = 1'b0;
    model_reset();
    #1;
    check("t6_reset_i", i_out, 0);
    check("t6_reset_q", q_out, 0);
    check("t6_reset_valid", iq_valid, 0);
    check("t6_reset_active", window_active, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      check("t6_no_early_pulse", iq_valid, 0);
    end
    step();
    check("t6_valid", iq_valid, 1);
    check("t6_i_clean", i_out, 20000);
    check("t6_q_clean", q_out, -5000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
